mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one port of the two-port program/data RAM among NREQ requesters, e.g. VGA fetch,
//  game-board updater and I/O writer. Round-robin arbitration, one access at a time.
//  Sits between the requesters and RAM port 2; port 1 stays owned by the CPU.
//  The RAM registers address/writes on negedge clk; this block drives it from posedge registers.
// PARAMETERS
//  NREQ        4   number of requesters (2..8)
//  DATA_WIDTH  16  RAM word width
//  ADDR_WIDTH  10  RAM address width
// PORTS
//  clk       in   1                 system clock; all logic on posedge
//  reset     in   1                 synchronous, active-high
//  req       in   NREQ              per-requester request; hold until matching ack
//  we        in   NREQ              1=write, 0=read; qualified by req
//  addr      in   NREQ*ADDR_WIDTH   requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  wdata     in   NREQ*DATA_WIDTH   requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  ack       out  NREQ              one-cycle pulse, one-hot: access i complete
//  rdata     out  DATA_WIDTH        read data; valid in the ack cycle, held until next ack
//  busy      out  1                 1 while in ACCESS
//  mem_addr  out  ADDR_WIDTH        to RAM addr2
//  mem_din   out  DATA_WIDTH        to RAM din2
//  mem_wen   out  1                 to RAM wen2
//  mem_dout  in   DATA_WIDTH        from RAM dout2
// BEHAVIOUR
//  Reset: state=IDLE, ack=0, rdata=0, busy=0, mem_wen=0, mem_addr=0, mem_din=0, rr_ptr=0.
//  FSM (2 states, all outputs registered):
//   IDLE: elig = req & ~ack. If elig!=0: pick winner g, latch addr/wdata/we of g into
//         mem_addr/mem_din/mem_wen, store g, busy<=1, go ACCESS. Else stay; mem_wen<=0.
//   ACCESS: RAM acts on the intervening negedge. Next posedge: rdata<=mem_dout (reads only;
//         writes leave rdata unchanged), ack[g]<=1, mem_wen<=0, busy<=0, rr_ptr<=(g+1)%NREQ,
//         go IDLE.
//  Latency: req sampled at edge E0 -> ack high after E1 -> requester sees ack at edge E2.
//  Throughput: max one access every 2 cycles.
//  Round-robin: search elig from rr_ptr upward, wrapping at NREQ-1 -> 0; first set bit wins.
//  The ack mask stops a requester still holding req in its ack cycle from being re-granted;
//  it is eligible again the cycle after.
//  A request dropped after grant still completes and is acked; dropped before grant is ignored.
//  Inputs of a non-granted requester may change freely; only the latched copy reaches the RAM.
//  Reset during ACCESS: abort, no ack, mem_wen<=0. A write already committed on the preceding
//  negedge stays in RAM.
// CONFIGURATION
//  ARB_PRIO0_EN defined: requester 0 wins whenever elig[0]=1, regardless of rr_ptr (VGA
//  real-time fetch). Other requesters stay round-robin among themselves; a req0 grant does
//  not move rr_ptr.
//  ARB_PRIO0_EN undefined: pure round-robin over all NREQ.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE, ACCESS}, NREQ_MAX=8, index width function clog2.
//  Sub-module rr_pick: combinational round-robin encoder.
//   Inputs: elig, rr_ptr. Outputs: grant index, any. Contains the ARB_PRIO0_EN override.
//  Top module holds the FSM, latches and output registers only.
// TESTING
//  1 Reset: assert 3 cycles mid-ACCESS of a write to 0x010.
//    -> no ack, mem_wen=0, busy=0, rdata=0 after reset.
//  2 Single write then read: req1 writes 0x0155=0xBEEF, then reads 0x0155.
//    -> ack[1] 2 edges after each req; read rdata=0xBEEF.
//  3 Contention: req=4'b1111 held, each drops req on its ack.
//    -> ack order 0,1,2,3, one every 2 cycles, no requester granted twice.
//  4 Wrap: rr_ptr=3 (after a grant to req2), req=4'b1001 -> grant 3 then 0.
//  5 Held req after ack: req2 held continuously with req0 also set.
//    -> grants alternate 2,0,2,0; never 2,2 back-to-back.
//  6 ARB_PRIO0_EN build: req=4'b1110 pending, req0 asserted.
//    -> req0 granted next IDLE; rr order among 1..3 unchanged. Undefined build -> rr order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the RAM port-2 arbiter.
//  state_e  : arbiter FSM states
//  NREQ_MAX : largest supported requester count
//  clog2    : index width for a given requester count
package mem_arb_pkg;

  localparam int unsigned NREQ_MAX = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Ceiling log2, used to size requester index fields.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin encoder for the RAM port-2 arbiter.
//  elig    in   NREQ  eligible requesters
//  rr_ptr  in   IW    highest-priority index for this pick
//  grant_c out  IW    winning index (valid when any_c)
//  any_c   out  1     at least one requester eligible
// Optional macro ARB_PRIO0_EN: requester 0 wins whenever it is eligible.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   grant_c,
  output logic            any_c
);
  import mem_arb_pkg::*;

  int unsigned idx;
  logic        found;

  // Search upward from rr_ptr, wrapping at NREQ-1; first set bit wins.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr) + i) % NREQ;
      if (!found && elig[idx[IW-1:0]]) begin
        found   = 1'b1;
        grant_c = IW'(idx);
      end
    end
`ifdef ARB_PRIO0_EN
    // Real-time requester 0 overrides the rotation.
    if (elig[0]) grant_c = '0;
`endif
  end

  assign any_c = |elig;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares RAM port 2 among NREQ requesters, one access at a time, round-robin.
// The RAM acts on negedge; this block presents address/data from posedge flops
// and captures read data on the following posedge.
//  clk, reset           clock, synchronous active-high reset
//  req/we/addr/wdata    per-requester request, direction, address, write data
//  ack                  one-cycle one-hot completion pulse
//  rdata                read data, valid in the ack cycle, held until next read
//  busy                 high while an access is in flight
//  mem_addr/din/wen     to RAM port 2; mem_dout from RAM port 2
// Optional macro ARB_PRIO0_EN: requester 0 has absolute priority (see rr_pick).
module mem_port_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       busy,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_din,
  output logic                       mem_wen,
  input  logic [DATA_WIDTH-1:0]      mem_dout
);
  import mem_arb_pkg::*;

  localparam int unsigned IW = clog2(NREQ);

  state_e                state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]       ack_q, ack_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  mem_wen_q, mem_wen_d;

  logic [NREQ-1:0]       elig_c;
  logic [IW-1:0]         pick_c;
  logic                  any_c;

  // A requester still holding req during its ack cycle must not be re-granted.
  assign elig_c = req & ~ack_q;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .elig    (elig_c),
    .rr_ptr  (rr_ptr_q),
    .grant_c (pick_c),
    .any_c   (any_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_wen_d  = mem_wen_q;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          gnt_d      = pick_c;
          mem_addr_d = addr[pick_c*ADDR_WIDTH +: ADDR_WIDTH];
          mem_din_d  = wdata[pick_c*DATA_WIDTH +: DATA_WIDTH];
          mem_wen_d  = we[pick_c];
          busy_d     = 1'b1;
          state_d    = ACCESS;
        end else begin
          mem_wen_d  = 1'b0;
        end
      end
      ACCESS: begin
        // RAM has acted on the intervening negedge; finish the access.
        if (!mem_wen_q) rdata_d = mem_dout;
        ack_d[gnt_q] = 1'b1;
        mem_wen_d    = 1'b0;
        busy_d       = 1'b0;
        rr_ptr_d     = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
`ifdef ARB_PRIO0_EN
        // Priority grants to requester 0 leave the rotation untouched.
        if (gnt_q == '0) rr_ptr_d = rr_ptr_q;
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_wen_q  <= mem_wen_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_wen  = mem_wen_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: negedge RAM model, scoreboard of expected acks.
// Expectations follow ARB_PRIO0_EN when the bench is built with it.
module tb_mem_port_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 10;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     we = '0;
  logic [NREQ*AW-1:0]  addr = '0;
  logic [NREQ*DW-1:0]  wdata = '0;
  logic [NREQ-1:0]     ack;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_din;
  logic                mem_wen;
  logic [DW-1:0]       mem_dout;
  logic [DW-1:0]       ram [0:1023];

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   rdata;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  mem_port_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wen  (mem_wen),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port 2 model: registers address and write on negedge.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) ram[10'h200 + i] = 16'hA000 + 16'(i);
    mem_dout = '0;
    forever begin
      @(negedge clk);
      if (mem_wen === 1'b1) ram[mem_addr] = mem_din;
      mem_dout = ram[mem_addr];
    end
  end

  task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic push_exp(input int id, input logic [DW-1:0] rd, input int c);
    exp_t e;
    e.ack = NREQ'(1 << id);
    e.rdata = rd;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive requests; each ack is popped against the scoreboard as it appears.
  task automatic run_reqs(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] late_mask,
                          input int late_it, input bit hold, input int n_acks, input string name);
    int   it;
    int   acked;
    exp_t e;
    it = 0;
    acked = 0;
    req = req | mask;
    forever begin
      if (it == late_it) req = req | late_mask;
      @(negedge clk);
      if (ack !== '0) begin
        acked++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected ack=%b rdata=%h", name, ack, rdata);
        end else begin
          e = exp_q.pop_front();
          if (ack !== e.ack || rdata !== e.rdata || (e.cyc >= 0 && cyc != e.cyc)) begin
            n_err++;
            $display("FAIL %s ack=%b rdata=%h cyc=%0d, required ack=%b rdata=%h cyc=%0d",
                     name, ack, rdata, cyc, e.ack, e.rdata, e.cyc);
          end
        end
        if (!hold) req = req & ~ack;
      end
      if (acked >= n_acks) break;
      if (it >= 60) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s timeout acked=%0d required %0d", name, acked, n_acks);
        break;
      end
      @(posedge clk);
      #1 it++;
    end
    req = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack, busy, mem_wen} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl ack=%b busy=%b wen=%b, required 0", ack, busy, mem_wen);
    end
    n_cmp++;
    if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata got %h required 0", rdata); end
    n_cmp++;
    if ({mem_addr, mem_din} !== '0) begin
      n_err++; $display("FAIL reset_mem addr=%h din=%h required 0", mem_addr, mem_din);
    end
    @(posedge clk);
    #1 set_port(0, 1'b1, 10'h010, 16'h1234);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, mem_wen, mem_addr, mem_din} !== {1'b1, 1'b1, 10'h010, 16'h1234}) begin
      n_err++; $display("FAIL reset_grant busy=%b wen=%b addr=%h din=%h, required 1 1 010 1234",
                        busy, mem_wen, mem_addr, mem_din);
    end
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (ack !== '0 || busy !== 1'b0 || mem_wen !== 1'b0) begin
        n_err++; $display("FAIL reset_abort ack=%b busy=%b wen=%b, required 0", ack, busy, mem_wen);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack, busy, mem_wen} !== 6'b0 || rdata !== '0) begin
      n_err++; $display("FAIL reset_after ack=%b busy=%b wen=%b rdata=%h, required 0",
                        ack, busy, mem_wen, rdata);
    end
    n_cmp++;
    if (ram[10'h010] !== 16'h1234) begin
      n_err++; $display("FAIL reset_committed ram=%h required 1234", ram[10'h010]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int c;
    set_port(1, 1'b1, 10'h155, 16'hBEEF);
    c = cyc;
    push_exp(1, 16'h0000, c + 2);
    run_reqs(4'b0010, '0, -1, 1'b0, 1, "single_write");
    n_cmp++;
    if (ram[10'h155] !== 16'hBEEF) begin
      n_err++; $display("FAIL single_ram got %h required beef", ram[10'h155]);
    end
    set_port(1, 1'b0, 10'h155, 16'h0000);
    c = cyc;
    push_exp(1, 16'hBEEF, c + 2);
    run_reqs(4'b0010, '0, -1, 1'b0, 1, "single_read");
  endtask

  task automatic test_contention();
    int c;
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 10'(10'h200 + i), '0);
    c = cyc;
    for (int i = 0; i < 4; i++) push_exp(i, 16'hA000 + 16'(i), c + 2 + 2 * i);
    run_reqs(4'b1111, '0, -1, 1'b0, 4, "contention");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL contention_left %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_port(2, 1'b0, 10'h202, '0);
    push_exp(2, 16'hA002, -1);
    run_reqs(4'b0100, '0, -1, 1'b0, 1, "wrap_setup");
    set_port(3, 1'b1, 10'h300, 16'h3333);
    set_port(0, 1'b1, 10'h301, 16'h0101);
`ifdef ARB_PRIO0_EN
    push_exp(0, 16'hA002, -1);
    push_exp(3, 16'hA002, -1);
`else
    push_exp(3, 16'hA002, -1);
    push_exp(0, 16'hA002, -1);
`endif
    run_reqs(4'b1001, '0, -1, 1'b0, 2, "wrap");
    n_cmp++;
    if (ram[10'h300] !== 16'h3333 || ram[10'h301] !== 16'h0101) begin
      n_err++; $display("FAIL wrap_ram got %h %h required 3333 0101", ram[10'h300], ram[10'h301]);
    end
  endtask

  task automatic test_held();
    set_port(0, 1'b0, 10'h200, '0);
    set_port(2, 1'b0, 10'h202, '0);
    for (int k = 0; k < 2; k++) begin
`ifdef ARB_PRIO0_EN
      push_exp(0, 16'hA000, -1);
      push_exp(2, 16'hA002, -1);
`else
      push_exp(2, 16'hA002, -1);
      push_exp(0, 16'hA000, -1);
`endif
    end
    run_reqs(4'b0101, '0, -1, 1'b1, 4, "held");
  endtask

  task automatic test_prio();
    do_reset();
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 10'(10'h200 + i), '0);
    push_exp(1, 16'hA001, -1);
`ifdef ARB_PRIO0_EN
    push_exp(0, 16'hA000, -1);
    push_exp(2, 16'hA002, -1);
    push_exp(3, 16'hA003, -1);
`else
    push_exp(2, 16'hA002, -1);
    push_exp(3, 16'hA003, -1);
    push_exp(0, 16'hA000, -1);
`endif
    run_reqs(4'b1110, 4'b0001, 1, 1'b0, 4, "prio");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL prio_left %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_held();
    test_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
